// File: rtl/rvcpu_muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: RV32M/RV64M funct3 opcodes and FSM states.
package rvcpu_muldiv_pkg;

    typedef enum logic [2:0] {
        md_mul,
        md_mulh,
        md_mulhsu,
        md_mulhu,
        md_div,
        md_divu,
        md_rem,
        md_remu
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } muldiv_state_t;

endpackage

// File: rtl/rvcpu_muldiv_step.sv
// Combinational datapath slice: BITS_PER_CYCLE shift-add (multiply) or restoring-subtract
// (divide) steps on the {acc, operand} register pair.
module rvcpu_muldiv_step
    import rvcpu_muldiv_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] acc_i,
    input  logic [XLEN-1:0] opnd_i,
    input  logic [XLEN-1:0] m_i,
    output logic [XLEN-1:0] acc_o,
    output logic [XLEN-1:0] opnd_o
);

    // One extra bit holds the add carry / the pre-compare shifted remainder.
    logic [XLEN:0]   acc;
    logic [XLEN-1:0] opnd;

    always_comb begin
        acc  = {1'b0, acc_i};
        opnd = opnd_i;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (is_div) begin
                acc  = {acc[XLEN-1:0], opnd[XLEN-1]};
                opnd = {opnd[XLEN-2:0], 1'b0};
                if (acc >= {1'b0, m_i}) begin
                    acc     = acc - {1'b0, m_i};
                    opnd[0] = 1'b1;
                end
            end else begin
                if (opnd[0]) begin
                    acc = acc + {1'b0, m_i};
                end
                {acc, opnd} = {1'b0, acc, opnd[XLEN-1:1]};
            end
        end
        acc_o  = acc[XLEN-1:0];
        opnd_o = opnd;
    end

endmodule

// File: rtl/rvcpu_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: magnitude datapath with sign fixup on completion,
// fast path for divide-by-zero, signed overflow and multiply by zero.
module rvcpu_muldiv
    import rvcpu_muldiv_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic [1:0]      dbg_state
);

    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N) + 1;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t   state_q;
    muldiv_op_t      op_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] acc_q, opnd_q, m_q, result_q;
    logic [4:0]      rd_q;
    logic            neg_q, out_valid_q;

    muldiv_op_t      op_in;
    logic            a_neg, b_neg, fast;
    logic [XLEN-1:0] a_mag, b_mag, fast_res;
    logic [XLEN-1:0] acc_d, opnd_d, quo, rem, fin_res;
    logic [2*XLEN-1:0] prod;

    assign op_in = muldiv_op_t'(in_op);

    always_comb begin
        a_neg = in_a[XLEN-1] &
                ((op_in == md_mulh) || (op_in == md_mulhsu) || (op_in == md_div) || (op_in == md_rem));
        b_neg = in_b[XLEN-1] & ((op_in == md_mulh) || (op_in == md_div) || (op_in == md_rem));
        a_mag = a_neg ? -in_a : in_a;
        b_mag = b_neg ? -in_b : in_b;
        fast     = 1'b0;
        fast_res = '0;
        // in_op[2] selects divide, in_op[1] remainder, in_op[0] unsigned divide.
        if (in_b == '0) begin
            fast     = 1'b1;
            fast_res = !in_op[2] ? '0 : (in_op[1] ? in_a : '1);
        end else if (in_op[2] && !in_op[0] && in_a == MIN_VAL && in_b == '1) begin
            fast     = 1'b1;
            fast_res = in_op[1] ? '0 : MIN_VAL;
        end
    end

    rvcpu_muldiv_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .is_div (op_q[2]),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .m_i    (m_q),
        .acc_o  (acc_d),
        .opnd_o (opnd_d)
    );

    // Final result is taken from the last step's outputs so DONE lands N+1 cycles after accept.
    always_comb begin
        prod = {acc_d, opnd_d};
        if (neg_q) begin
            prod = -prod;
        end
        quo = neg_q ? -opnd_d : opnd_d;
        rem = neg_q ? -acc_d : acc_d;
        case (op_q)
            md_mul:                        fin_res = prod[XLEN-1:0];
            md_mulh, md_mulhsu, md_mulhu:  fin_res = prod[2*XLEN-1:XLEN];
            md_div, md_divu:               fin_res = quo;
            default:                       fin_res = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            m_q         <= '0;
            neg_q       <= 1'b0;
            op_q        <= md_mul;
            rd_q        <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q   <= op_in;
                        rd_q   <= in_rd;
                        neg_q  <= (in_op[2] && in_op[1]) ? a_neg : (a_neg ^ b_neg);
                        cnt_q  <= '0;
                        acc_q  <= '0;
                        opnd_q <= in_op[2] ? a_mag : b_mag;
                        m_q    <= in_op[2] ? b_mag : a_mag;
                        if (fast) begin
                            result_q    <= fast_res;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q  <= acc_d;
                    opnd_q <= opnd_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        result_q    <= fin_res;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign out_result = result_q;
    assign out_rd     = rd_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_rvcpu_muldiv.sv
// Bench for rvcpu_muldiv: radix-1 and radix-4 instances checked against an arithmetic reference.
module tb_rvcpu_muldiv;
    import rvcpu_muldiv_pkg::*;

    localparam logic [31:0] MIN32 = 32'h8000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, out_ready;
    logic        in_valid_1, in_valid_4;
    logic [2:0]  in_op;
    logic [31:0] in_a, in_b;
    logic [4:0]  in_rd;
    logic        in_ready_1, out_valid_1, in_ready_4, out_valid_4;
    logic [31:0] out_result_1, out_result_4;
    logic [4:0]  out_rd_1, out_rd_4;
    logic [1:0]  dbg_state_1, dbg_state_4;

    int n_checks = 0;
    int n_fail   = 0;

    rvcpu_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid_1), .in_ready(in_ready_1),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .out_valid(out_valid_1),
        .out_ready(out_ready), .out_result(out_result_1), .out_rd(out_rd_1), .dbg_state(dbg_state_1)
    );

    rvcpu_muldiv #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid_4), .in_ready(in_ready_4),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .out_valid(out_valid_4),
        .out_ready(out_ready), .out_result(out_result_4), .out_rd(out_rd_4), .dbg_state(dbg_state_4)
    );

    function automatic logic f_valid(int sel);
        return (sel == 1) ? out_valid_1 : out_valid_4;
    endfunction
    function automatic logic f_ready(int sel);
        return (sel == 1) ? in_ready_1 : in_ready_4;
    endfunction
    function automatic logic [31:0] f_result(int sel);
        return (sel == 1) ? out_result_1 : out_result_4;
    endfunction
    function automatic logic [4:0] f_rd(int sel);
        return (sel == 1) ? out_rd_1 : out_rd_4;
    endfunction
    function automatic logic [1:0] f_state(int sel);
        return (sel == 1) ? dbg_state_1 : dbg_state_4;
    endfunction

    task automatic set_valid(input int sel, input logic v);
        if (sel == 1) in_valid_1 = v;
        else in_valid_4 = v;
    endtask

    // Reference: RISC-V M semantics computed with 64-bit integer arithmetic.
    function automatic logic [31:0] ref_md(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        longint sa, sb, ub, p;
        longint unsigned ua_u, ub_u, pu;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ub   = {32'd0, b};
        ua_u = {32'd0, a};
        ub_u = {32'd0, b};
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin pu = ua_u * ub_u; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int exp_lat(int sel, logic [2:0] op, logic [31:0] a, logic [31:0] b);
        bit fast;
        fast = (b == 0) || ((op == 3'd4 || op == 3'd6) && a == MIN32 && b == 32'hFFFF_FFFF);
        return fast ? 1 : (32 / sel) + 1;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return MIN32;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issues one op and waits (bounded) for out_valid; returns at a negedge with the result visible.
    task automatic run_op(input int sel, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                          output int lat, output bit to);
        @(negedge clk);
        in_op = op; in_a = a; in_b = b; in_rd = rd;
        set_valid(sel, 1'b1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        set_valid(sel, 1'b0);
        while (!f_valid(sel) && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        to  = !f_valid(sel);
        res = f_result(sel);
        rdo = f_rd(sel);
    endtask

    task automatic test_reset();
        int sel;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            sel = (k == 0) ? 1 : 4;
            n_checks++;
            if (f_ready(sel) !== 1'b1) begin
                n_fail++; $display("FAIL reset_in_ready bpc=%0d got %b want 1", sel, f_ready(sel));
            end
            n_checks++;
            if (f_valid(sel) !== 1'b0) begin
                n_fail++; $display("FAIL reset_out_valid bpc=%0d got %b want 0", sel, f_valid(sel));
            end
            n_checks++;
            if (f_result(sel) !== 32'd0 || f_rd(sel) !== 5'd0) begin
                n_fail++; $display("FAIL reset_outputs bpc=%0d got %h/%0d want 0/0", sel, f_result(sel), f_rd(sel));
            end
            n_checks++;
            if (f_state(sel) !== IDLE) begin
                n_fail++; $display("FAIL reset_state bpc=%0d got %0d want %0d", sel, f_state(sel), IDLE);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_directed(input int sel);
        logic [2:0]  ops [12];
        logic [31:0] va [12], vb [12], ve [12];
        bit          vf [12];
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat, want_lat;
        bit          to;
        ops = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
        va  = '{32'd7, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
        vb  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd2, 32'd2,
                32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        ve  = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        vf  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
        for (int i = 0; i < 12; i++) begin
            run_op(sel, ops[i], va[i], vb[i], 5'(i + 1), res, rdo, lat, to);
            want_lat = vf[i] ? 1 : (32 / sel) + 1;
            n_checks++;
            if (to) begin
                n_fail++; $display("FAIL directed_timeout[%0d] bpc=%0d no out_valid within %0d cycles", i, sel, lat);
                continue;
            end
            if (res !== ve[i]) begin
                n_fail++; $display("FAIL directed_result[%0d] bpc=%0d got %h want %h", i, sel, res, ve[i]);
            end
            n_checks++;
            if (rdo !== 5'(i + 1)) begin
                n_fail++; $display("FAIL directed_rd[%0d] bpc=%0d got %0d want %0d", i, sel, rdo, i + 1);
            end
            n_checks++;
            if (lat != want_lat) begin
                n_fail++; $display("FAIL directed_latency[%0d] bpc=%0d got %0d want %0d", i, sel, lat, want_lat);
            end
        end
    endtask

    task automatic test_random(input int sel);
        logic [2:0]  op;
        logic [31:0] a, b, res, exp;
        logic [4:0]  rd, rdo;
        int          lat;
        bit          to;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            rd = 5'($urandom_range(0, 31));
            exp = ref_md(op, a, b);
            run_op(sel, op, a, b, rd, res, rdo, lat, to);
            n_checks++;
            if (to) begin
                n_fail++; $display("FAIL random_timeout[%0d] bpc=%0d op=%0d no out_valid", i, sel, op);
                continue;
            end
            if (res !== exp) begin
                n_fail++; $display("FAIL random_result[%0d] bpc=%0d op=%0d a=%h b=%h got %h want %h",
                                   i, sel, op, a, b, res, exp);
            end
            n_checks++;
            if (rdo !== rd || lat != exp_lat(sel, op, a, b)) begin
                n_fail++; $display("FAIL random_rd_lat[%0d] bpc=%0d got rd=%0d lat=%0d want rd=%0d lat=%0d",
                                   i, sel, rdo, lat, rd, exp_lat(sel, op, a, b));
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] a, b, res, exp;
        logic [4:0]  rdo;
        int          lat;
        bit          to, bad;
        a = $urandom; b = $urandom | 32'd1;
        exp = ref_md(3'd0, a, b);
        out_ready = 1'b0;
        run_op(1, 3'd0, a, b, 5'd17, res, rdo, lat, to);
        n_checks++;
        if (to || res !== exp) begin
            n_fail++; $display("FAIL hold_result got %h (timeout=%0d) want %h", res, to, exp);
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid_1 !== 1'b1 || out_result_1 !== exp || out_rd_1 !== 5'd17 || in_ready_1 !== 1'b0) begin
                bad = 1'b1;
                $display("FAIL hold_stable cycle %0d got v=%b r=%h rd=%0d rdy=%b want v=1 r=%h rd=17 rdy=0",
                         i, out_valid_1, out_result_1, out_rd_1, in_ready_1, exp);
            end
        end
        n_checks++;
        if (bad) n_fail++;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid_1 !== 1'b0 || in_ready_1 !== 1'b1) begin
            n_fail++; $display("FAIL hold_release got v=%b rdy=%b want v=0 rdy=1", out_valid_1, in_ready_1);
        end
    endtask

    task automatic test_flush(input bit use_rst);
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        bit          to, saw;
        @(negedge clk);
        in_op = 3'd5; in_a = $urandom; in_b = 32'($urandom_range(1, 1000)); in_rd = 5'd9;
        in_valid_1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_1 = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        if (use_rst) rst = 1'b1;
        else flush = 1'b1;
        in_valid_1 = 1'b1; in_op = 3'd0; in_a = 32'd3; in_b = 32'd4;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; in_valid_1 = 1'b0;
        n_checks++;
        if (in_ready_1 !== 1'b1 || dbg_state_1 !== IDLE || out_valid_1 !== 1'b0) begin
            n_fail++; $display("FAIL abort_calc rst=%0d got rdy=%b st=%0d v=%b want rdy=1 st=0 v=0",
                               use_rst, in_ready_1, dbg_state_1, out_valid_1);
        end
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid_1 !== 1'b0) saw = 1'b1;
        end
        n_checks++;
        if (saw) begin
            n_fail++; $display("FAIL abort_no_output rst=%0d got out_valid=1 want 0", use_rst);
        end
        run_op(1, 3'd0, 32'd3, 32'd4, 5'd4, res, rdo, lat, to);
        n_checks++;
        if (to || res !== 32'd12 || lat != 33) begin
            n_fail++; $display("FAIL abort_followup rst=%0d got %h lat=%0d want 0000000c lat=33", use_rst, res, lat);
        end
        if (!use_rst) begin
            out_ready = 1'b0;
            run_op(1, 3'd4, 32'd5, 32'd0, 5'd6, res, rdo, lat, to);
            flush = 1'b1;
            @(posedge clk);
            @(negedge clk);
            flush = 1'b0;
            out_ready = 1'b1;
            n_checks++;
            if (out_valid_1 !== 1'b0 || dbg_state_1 !== IDLE) begin
                n_fail++; $display("FAIL flush_done got v=%b st=%0d want v=0 st=0", out_valid_1, dbg_state_1);
            end
            flush = 1'b1; in_valid_1 = 1'b1; in_op = 3'd0; in_a = 32'd1; in_b = 32'd1;
            @(posedge clk);
            @(negedge clk);
            flush = 1'b0; in_valid_1 = 1'b0;
            n_checks++;
            if (dbg_state_1 !== IDLE || in_ready_1 !== 1'b1) begin
                n_fail++; $display("FAIL flush_blocks_accept got st=%0d rdy=%b want st=0 rdy=1", dbg_state_1, in_ready_1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        bit          to;
        out_ready = 1'b1;
        run_op(4, 3'd0, 32'd5, 32'd6, 5'd1, res, rdo, lat, to);
        n_checks++;
        if (to || res !== 32'd30) begin
            n_fail++; $display("FAIL b2b_first got %h want 0000001e", res);
        end
        in_valid_4 = 1'b1; in_op = 3'd5; in_a = 32'd50; in_b = 32'd5; in_rd = 5'd2;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (dbg_state_4 !== IDLE || in_ready_4 !== 1'b1 || out_valid_4 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_no_accept_in_done got st=%0d rdy=%b v=%b want st=0 rdy=1 v=0",
                               dbg_state_4, in_ready_4, out_valid_4);
        end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid_4 = 1'b0;
        n_checks++;
        if (dbg_state_4 !== CALC) begin
            n_fail++; $display("FAIL b2b_accept got st=%0d want %0d", dbg_state_4, CALC);
        end
        while (!out_valid_4 && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        n_checks++;
        if (out_valid_4 !== 1'b1 || out_result_4 !== 32'd10 || out_rd_4 !== 5'd2 || lat != 9) begin
            n_fail++; $display("FAIL b2b_second got v=%b r=%h rd=%0d lat=%0d want v=1 r=0000000a rd=2 lat=9",
                               out_valid_4, out_result_4, out_rd_4, lat);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid_1 = 1'b0; in_valid_4 = 1'b0;
        in_op = 3'd0; in_a = '0; in_b = '0; in_rd = '0;
        test_reset();
        test_directed(1);
        test_directed(4);
        test_random(1);
        test_random(4);
        test_hold();
        test_flush(1'b0);
        test_flush(1'b1);
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog simulation did not complete in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
